// File: rtl/led_ctrl.sv
// Per-channel LED mode controller (OFF / ON / BLINK) driven by single-cycle tick pulses.
// All blinking channels follow one free-running prescaler so they stay in phase.
module led_ctrl #(
    parameter int N              = 4,
    parameter int BLINK_DIV      = 25_000_000,
    parameter int LED_ACTIVE_LOW = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     on_tick,
    input  logic [N-1:0]     off_tick,
    input  logic [N-1:0]     blink_tick,
    output logic [2*N-1:0]   mode,
    output logic             phase,
    output logic [N-1:0]     LEDS
);

    localparam int              CNT_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);
    localparam logic [N-1:0]    LED_POL = (LED_ACTIVE_LOW != 0) ? {N{1'b1}} : {N{1'b0}};

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10
    } mode_t;

    mode_t            mode_r     [N];
    mode_t            mode_nxt_s [N];
    logic [CNT_W-1:0] cnt_r;
    logic             phase_r;
    logic             phase_nxt_s;
    logic             wrap_s;
    logic [N-1:0]     lit_s;
    logic [N-1:0]     leds_r;

    // Off outranks on, which outranks blink; no tick keeps the current mode.
    function automatic mode_t next_mode(input mode_t cur, input logic off_t,
                                        input logic on_t, input logic blink_t);
        mode_t nxt;
        if (off_t) begin
            nxt = MODE_OFF;
        end else if (on_t) begin
            nxt = MODE_ON;
        end else if (blink_t) begin
            nxt = MODE_BLINK;
        end else begin
            nxt = cur;
        end
        return nxt;
    endfunction

    // Prescaler wrap detection and the phase value that will hold after this edge.
    always_comb begin
        wrap_s      = (cnt_r == CNT_MAX);
        phase_nxt_s = phase_r;
        if (wrap_s) begin
            phase_nxt_s = ~phase_r;
        end else begin
            phase_nxt_s = phase_r;
        end
    end

    // Next mode per channel and the lit state it implies after this edge.
    always_comb begin
        lit_s = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            mode_nxt_s[i] = next_mode(mode_r[i], off_tick[i], on_tick[i], blink_tick[i]);
            case (mode_nxt_s[i])
                MODE_OFF:   lit_s[i] = 1'b0;
                MODE_ON:    lit_s[i] = 1'b1;
                MODE_BLINK: lit_s[i] = phase_nxt_s;
                default:    lit_s[i] = 1'b0;
            endcase
        end
    end

    // Prescaler, shared phase, channel state machines and registered LED drive.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r   <= {CNT_W{1'b0}};
            phase_r <= 1'b0;
            leds_r  <= LED_POL;
            for (int i = 0; i < N; i++) begin
                mode_r[i] <= MODE_OFF;
            end
        end else begin
            if (wrap_s) begin
                cnt_r <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
            phase_r <= phase_nxt_s;
            leds_r  <= lit_s ^ LED_POL;
            for (int i = 0; i < N; i++) begin
                mode_r[i] <= mode_nxt_s[i];
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_mode_pack
        assign mode[2*g +: 2] = mode_r[g];
    end

    assign phase = phase_r;
    assign LEDS  = leds_r;

endmodule

// File: tb/tb_led_ctrl.sv
// Directed self-checking bench for led_ctrl (BLINK_DIV=4), plus an active-low instance.
module tb_led_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] on_tick = 4'b0000;
    logic [3:0] off_tick = 4'b0000;
    logic [3:0] blink_tick = 4'b0000;
    logic [7:0] mode;
    logic       phase;
    logic [3:0] leds;

    logic       reset2 = 1'b0;
    logic [3:0] on2 = 4'b0000;
    logic [3:0] off2 = 4'b0000;
    logic [3:0] blink2 = 4'b0000;
    logic [7:0] mode2;
    logic       phase2;
    logic [3:0] leds2;

    int tests = 0;
    int fails = 0;
    int e     = 0;   // rising edges since the last reset release of dut
    logic p;

    always #5 clk = ~clk;

    led_ctrl #(.N(4), .BLINK_DIV(4), .LED_ACTIVE_LOW(0)) dut (
        .clk(clk), .reset(reset), .on_tick(on_tick), .off_tick(off_tick),
        .blink_tick(blink_tick), .mode(mode), .phase(phase), .LEDS(leds)
    );

    led_ctrl #(.N(4), .BLINK_DIV(4), .LED_ACTIVE_LOW(1)) dut_al (
        .clk(clk), .reset(reset2), .on_tick(on2), .off_tick(off2),
        .blink_tick(blink2), .mode(mode2), .phase(phase2), .LEDS(leds2)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        e++;
        #1;
    endtask

    function automatic logic exp_phase(input int edges);
        return ((edges / 4) % 2) == 1;
    endfunction

    initial begin
        // Reset held low
        step();
        step();
        check("rst_mode", mode, 8'h00);
        check("rst_leds", {4'h0, leds}, 8'h00);
        check("rst_phase", {7'h0, phase}, 8'h00);
        check("al_rst_leds", {4'h0, leds2}, 8'h0f);

        // 1: idle after release, phase toggles every 4 edges
        reset = 1'b1;
        e = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            check("idle_phase", {7'h0, phase}, {7'h0, exp_phase(e)});
            check("idle_leds", {4'h0, leds}, 8'h00);
        end
        check("idle_mode", mode, 8'h00);

        // 2: on then off on channel 0
        on_tick = 4'b0001;
        step();
        on_tick = 4'b0000;
        check("on0_leds", {4'h0, leds}, 8'h01);
        check("on0_mode", mode, 8'h01);
        off_tick = 4'b0001;
        step();
        off_tick = 4'b0000;
        check("off0_leds", {4'h0, leds}, 8'h00);
        check("off0_mode", mode, 8'h00);

        // 3: blink channels 1 and 2
        blink_tick = 4'b0110;
        step();
        blink_tick = 4'b0000;
        check("blink_mode", mode, 8'b0010_1000);
        for (int i = 0; i < 16; i++) begin
            p = exp_phase(e);
            check("blink_leds", {4'h0, leds}, {4'h0, 1'b0, p, p, 1'b0});
            check("blink_phase", {7'h0, phase}, {7'h0, p});
            step();
        end

        // Re-issued blink is a no-op and does not disturb the phase
        blink_tick = 4'b0110;
        step();
        blink_tick = 4'b0000;
        p = exp_phase(e);
        check("reblink_leds", {4'h0, leds}, {4'h0, 1'b0, p, p, 1'b0});
        check("reblink_phase", {7'h0, phase}, {7'h0, p});

        // 4: priority
        on_tick = 4'b1111;
        off_tick = 4'b1111;
        blink_tick = 4'b1111;
        step();
        off_tick = 4'b0000;
        check("prio_all_mode", mode, 8'h00);
        check("prio_all_leds", {4'h0, leds}, 8'h00);
        // on+blink held for 3 cycles behaves like one command
        for (int i = 0; i < 3; i++) begin
            step();
            check("prio_on_mode", mode, 8'h55);
            check("prio_on_leds", {4'h0, leds}, 8'h0f);
        end
        on_tick = 4'b0000;
        blink_tick = 4'b0000;

        // 5: ch0 BLINK, ch1 ON, ch2 BLINK, ch3 OFF
        blink_tick = 4'b0101;
        off_tick = 4'b1000;
        step();
        blink_tick = 4'b0000;
        off_tick = 4'b0000;
        check("mix_mode", mode, 8'h26);
        for (int i = 0; i < 4 && (e % 4) != 2; i++) begin
            p = exp_phase(e);
            check("mix_leds", {4'h0, leds}, {4'h0, 1'b0, p, 1'b1, p});
            step();
        end
        p = exp_phase(e);
        check("mix_leds_mid", {4'h0, leds}, {4'h0, 1'b0, p, 1'b1, p});

        // Asynchronous reset mid-period
        reset = 1'b0;
        #1;
        check("arst_leds", {4'h0, leds}, 8'h00);
        check("arst_mode", mode, 8'h00);
        check("arst_phase", {7'h0, phase}, 8'h00);
        for (int i = 0; i < 3; i++) begin
            step();
            check("arst_hold_mode", mode, 8'h00);
            check("arst_hold_leds", {4'h0, leds}, 8'h00);
        end

        // Release with a tick present on the first edge
        reset = 1'b1;
        on_tick = 4'b0010;
        e = 0;
        step();
        on_tick = 4'b0000;
        check("rel_mode", mode, 8'h04);
        check("rel_leds", {4'h0, leds}, 8'h02);
        for (int i = 0; i < 8; i++) begin
            check("rel_phase", {7'h0, phase}, {7'h0, exp_phase(e)});
            step();
        end

        // 6: active-low instance
        reset2 = 1'b1;
        on2 = 4'b1000;
        step();
        on2 = 4'b0000;
        check("al_on_leds", {4'h0, leds2}, 8'h07);
        check("al_on_mode", mode2, 8'h40);
        reset2 = 1'b0;
        #1;
        check("al_rst2_leds", {4'h0, leds2}, 8'h0f);
        step();
        check("al_rst2_hold", {4'h0, leds2}, 8'h0f);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute time limit so the bench always ends
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/led_ctrl.md
Name: led_ctrl

Overview:
- Output-side counterpart of the button input chain (inverter → debouncer → edge detector).
- Consumes single-cycle tick pulses from the edge detectors and drives the board LEDs.
- Each LED channel is a small state machine with three modes: OFF, ON and BLINK.
- All blinking channels share one free-running prescaler, so they blink in phase.

Parameters:
- N, 4, number of LED channels.
- BLINK_DIV, 25_000_000, clock cycles per blink half-period (must be ≥ 2); full blink period is 2*BLINK_DIV cycles.
- LED_ACTIVE_LOW, 0, when 1, LEDS is inverted at the output (the internal lit state is unchanged).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- on_tick  input  N  per-channel single-cycle pulse: go to ON.
- off_tick  input  N  per-channel single-cycle pulse: go to OFF.
- blink_tick  input  N  per-channel single-cycle pulse: go to BLINK.
- mode  output  2N  per-channel mode code, channel i at bits [2i+1:2i]: 00 OFF, 01 ON, 10 BLINK.
- phase  output  1  shared blink phase (1 = lit half).
- LEDS  output  N  LED drive.

Behaviour:
- Reset (reset=0, asynchronous):
  - every channel goes to OFF (mode=00);
  - prescaler count = 0, phase = 0;
  - LEDS = all 0, or all 1 if LED_ACTIVE_LOW;
  - all of these hold while reset is low.
- Prescaler:
  - counter width is $clog2(BLINK_DIV); it counts 0..BLINK_DIV-1 and wraps to 0;
  - on the cycle where count = BLINK_DIV-1, phase toggles at the same edge as the wrap;
  - it runs continuously, whether or not any channel is in BLINK;
  - the first phase toggle after reset release occurs at edge number BLINK_DIV.
- Channel FSM, evaluated independently per channel i at each rising edge:
  - off_tick[i]=1 → OFF
  - else if on_tick[i]=1 → ON
  - else if blink_tick[i]=1 → BLINK
  - else hold the current mode.
  - Priority when ticks are simultaneous: off > on > blink.
  - A tick matching the current mode is a no-op; it does not restart the prescaler or affect phase.
- LED value (lit state):
  - OFF → 0;
  - ON → 1;
  - BLINK → the phase value in effect after that same edge.
- Registers and latency:
  - LEDS and mode are registered outputs.
  - A tick asserted in cycle k is visible on mode/LEDS from cycle k+1 (1-cycle latency).
  - Entering BLINK shows the current shared phase immediately; there is no local restart, so channels stay in phase.
- Input assumptions:
  - Tick inputs are 1-cycle pulses.
  - A tick held high for several cycles behaves as a repeated command, with the same result as a single pulse.
- Reset mid-operation:
  - An asynchronous assert immediately forces every output to its reset value.
  - On release, the first edge with reset=1 applies normal rules; a tick present on that edge is honoured.
- Channels are fully independent; a tick on channel i never changes channel j.

Test Plan (N=4, BLINK_DIV=4, LED_ACTIVE_LOW=0 unless stated):
1. Release reset, no ticks for 20 cycles → mode=8'h00, LEDS=4'b0000; phase toggles at edges 4, 8, 12, 16 after release.
2. on_tick=4'b0001 for one cycle at cycle k → at k+1, LEDS=4'b0001 and mode[1:0]=01. Then off_tick=4'b0001 → LEDS=4'b0000 next cycle.
3. blink_tick=4'b0110 → mode=8'b0010_1000; LEDS[2:1] equal {phase,phase} every cycle with period 8 cycles, and LEDS[0], LEDS[3] stay 0.
4. Simultaneous on_tick=off_tick=blink_tick=4'b1111 → all channels OFF. on_tick=blink_tick=4'b1111 → all ON.
5. Channels 0–3 in BLINK/ON/BLINK/OFF, then reset asserted mid-period for 3 cycles → LEDS=0, mode=0 and phase=0 immediately; after release, the prescaler restarts from 0.
6. LED_ACTIVE_LOW=1, on_tick=4'b1000 → LEDS=4'b0111; with reset held low, LEDS=4'b1111.
